// File: rtl/memory_pkg.sv
// Shared memory sizing constants and word/address types used by the
// processor datapath and the memory_ip store.
package memory_pkg;

  localparam int MEM_ADDR_WIDTH = 9;
  localparam int MEM_DATA_WIDTH = 16;
  localparam int MEM_DEPTH      = 2 ** MEM_ADDR_WIDTH;

  typedef logic [MEM_ADDR_WIDTH-1:0] mem_addr_t;
  typedef logic [MEM_DATA_WIDTH-1:0] mem_word_t;

endpackage

// File: rtl/memory_ip.sv
// Single-port synchronous RAM with a registered, asynchronously clearable
// read output. Reads return the old word when written on the same edge.
module memory_ip
  import memory_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wren,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] q
);

  // Power-up contents are zero; the array is never reset so it maps to block RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [DATA_WIDTH-1:0] q_d;
  logic [DATA_WIDTH-1:0] q_q;

  always_ff @(posedge clock) begin
    if (wren) begin
      mem[address] <= data;
    end
  end

  always_comb begin
    q_d = q_q;
    if (rden) begin
      q_d = mem[address];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_memory_ip.sv
// Directed bench for memory_ip: a reference array predicts every read,
// expected words are queued on rden and popped once the output edge passes.
module tb_memory_ip;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [8:0]  address;
  logic [15:0] data;
  logic        wren;
  logic        rden;
  logic [15:0] q;

  logic [15:0] model [512];
  logic [15:0] exp_q [$];
  logic [15:0] last_q;
  int          checks;
  int          failures;

  memory_ip dut (
    .clock   (clock),
    .reset_n (reset_n),
    .address (address),
    .data    (data),
    .wren    (wren),
    .rden    (rden),
    .q       (q)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs, predict the read result, then step past the edge.
  task automatic applyStimulus(input logic w, input logic r,
                               input logic [8:0] a, input logic [15:0] d);
    wren    = w;
    rden    = r;
    address = a;
    data    = d;
    if (r && reset_n) exp_q.push_back(model[a]);
    if (w) model[a] = d;
    @(posedge clock);
    #1;
  endtask

  // Compare q to the next queued read, or to the held value when nothing is queued.
  task automatic checkOutput(input string tag);
    if (exp_q.size() > 0) last_q = exp_q.pop_front();
    checks++;
    assert (q === last_q) else begin
      failures++;
      $error("[TB] FAIL %s q=%h expected=%h", tag, q, last_q);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    last_q   = '0;
    for (int i = 0; i < 512; i++) model[i] = '0;
    reset_n = 1'b0;
    wren    = 1'b0;
    rden    = 1'b0;
    address = '0;
    data    = '0;

    // Reset pulse, then directed writes with q expected to stay at zero.
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_state");
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 9'd1, 16'd64);
    checkOutput("write1_q_hold");
    applyStimulus(1'b1, 1'b0, 9'd2, 16'd65);
    checkOutput("write2_q_hold");

    // Read latency and hold behaviour.
    applyStimulus(1'b0, 1'b1, 9'd1, 16'd0);
    checkOutput("read_addr1");
    applyStimulus(1'b0, 1'b0, 9'd2, 16'd0);
    checkOutput("hold_after_read");
    applyStimulus(1'b1, 1'b0, 9'd2, 16'd65);
    checkOutput("hold_during_write");
    applyStimulus(1'b0, 1'b1, 9'd2, 16'd0);
    checkOutput("read_addr2");

    // Top address and an untouched word.
    applyStimulus(1'b1, 1'b0, 9'd511, 16'hFFFF);
    checkOutput("write511_hold");
    applyStimulus(1'b0, 1'b1, 9'd511, 16'd0);
    checkOutput("read_addr511");
    applyStimulus(1'b0, 1'b1, 9'd0, 16'd0);
    checkOutput("read_addr0");

    // Simultaneous write and read returns the old word.
    applyStimulus(1'b1, 1'b0, 9'd3, 16'h1234);
    checkOutput("write3_hold");
    applyStimulus(1'b1, 1'b1, 9'd3, 16'hABCD);
    checkOutput("rbw_old_data");
    applyStimulus(1'b0, 1'b1, 9'd3, 16'd0);
    checkOutput("rbw_new_data");

    // Asynchronous reset in mid-cycle, a write under reset, then read-back.
    applyStimulus(1'b0, 1'b1, 9'd2, 16'd0);
    checkOutput("read65_before_reset");
    #3;
    reset_n = 1'b0;
    #1;
    last_q = '0;
    checkOutput("async_reset_clear");
    applyStimulus(1'b1, 1'b0, 9'd4, 16'h5A5A);
    checkOutput("write_under_reset");
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 9'd2, 16'd0);
    checkOutput("retained_after_reset");
    applyStimulus(1'b0, 1'b1, 9'd4, 16'd0);
    checkOutput("write_during_reset_kept");

    // Idle cycles with wandering address/data must change nothing.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 9'($urandom), 16'($urandom));
      checkOutput("idle_hold");
    end
    applyStimulus(1'b0, 1'b1, 9'd1, 16'd0);
    checkOutput("idle_readback1");
    applyStimulus(1'b0, 1'b1, 9'd2, 16'd0);
    checkOutput("idle_readback2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
